uart_tx_frame: RTL and testbench

//  - UART transmitter: serializes one parallel word into a frame of

---
 rtl/uart_tx_frame.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// Optional per-bit prescaler enabled by defining UART_TX_PRESCALE_EN.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
`ifdef UART_TX_PRESCALE_EN
    ,
    parameter int PRESC_W    = 6
`endif
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
`ifdef UART_TX_PRESCALE_EN
    input  logic [PRESC_W-1:0]    PRESCALE,
`endif
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Even parity is the XOR of the word; odd parity is its complement.
    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                    par_q, par_d;
    logic                    par_en_q, par_en_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    accept_s;
    logic                    bit_end_s;

    assign accept_s = (state_q == ST_IDLE) && Data_Valid;

`ifdef UART_TX_PRESCALE_EN
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] div_q, div_d;

    function automatic logic [PRESC_W-1:0] eff_presc(input logic [PRESC_W-1:0] p);
        return (p == {PRESC_W{1'b0}}) ? {{(PRESC_W-1){1'b0}}, 1'b1} : p;
    endfunction

    assign bit_end_s = (div_q == {PRESC_W{1'b0}});

    // Bit-time down-counter: reloaded at the start of every bit, latched prescale at acceptance.
    always_comb begin
        presc_d = presc_q;
        div_d   = div_q;
        if (state_q == ST_IDLE) begin
            if (accept_s) begin
                presc_d = eff_presc(PRESCALE);
                div_d   = eff_presc(PRESCALE) - {{(PRESC_W-1){1'b0}}, 1'b1};
            end else begin
                div_d   = {PRESC_W{1'b0}};
            end
        end else if (bit_end_s) begin
            div_d = presc_q - {{(PRESC_W-1){1'b0}}, 1'b1};
        end else begin
            div_d = div_q - {{(PRESC_W-1){1'b0}}, 1'b1};
        end
    end

    // Prescaler registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            presc_q <= {{(PRESC_W-1){1'b0}}, 1'b1};
            div_q   <= {PRESC_W{1'b0}};
        end else begin
            presc_q <= presc_d;
            div_q   <= div_d;
        end
    end
`else
    assign bit_end_s = 1'b1;
`endif

    // Frame sequencing; the output flops are loaded with the value of the state being entered.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        par_en_d  = par_en_q;
        tx_d      = 1'b1;
        busy_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d   = ST_START;
                    data_d    = P_DATA;
                    par_en_d  = PAR_EN;
                    par_d     = parity_bit(P_DATA, PAR_TYP);
                    bit_cnt_d = {CNT_W{1'b0}};
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = {CNT_W{1'b0}};
                end else begin
                    state_d   = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        data_d    = data_q >> 1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_IDLE:   begin tx_d = 1'b1;      busy_d = 1'b0; end
            ST_START:  begin tx_d = 1'b0;      busy_d = 1'b1; end
            ST_DATA:   begin tx_d = data_d[0]; busy_d = 1'b1; end
            ST_PARITY: begin tx_d = par_q;     busy_d = 1'b1; end
            ST_STOP:   begin tx_d = 1'b1;      busy_d = 1'b1; end
            default:   begin tx_d = 1'b1;      busy_d = 1'b0; end
        endcase
    end

    // State, datapath and output registers; reset aborts any frame in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            data_q    <= {DATA_WIDTH{1'b0}};
            bit_cnt_q <= {CNT_W{1'b0}};
            par_q     <= 1'b0;
            par_en_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            par_en_q  <= par_en_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: directed frames plus randomized traffic
// compared against a frame-list reference model.
module tb_uart_tx_frame;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
`ifdef UART_TX_PRESCALE_EN
    logic [5:0] PRESCALE;
    logic [5:0] cur_ps = 6'd4;
`endif
    logic       TX_OUT;
    logic       Busy;

    int n_cmp = 0;
    int n_err = 0;

    logic frame_bits[$];
    int   pos  = -1;
    int   hold = 1;
    logic exp_tx   = 1'b1;
    logic exp_busy = 1'b0;

    always #5 CLK = ~CLK;

    uart_tx_frame #(
        .DATA_WIDTH(8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
`ifdef UART_TX_PRESCALE_EN
        .PRESCALE  (PRESCALE),
`endif
        .TX_OUT    (TX_OUT),
        .Busy      (Busy)
    );

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: a frame is a list of line levels; each level lasts 'hold' cycles.
    function automatic void model_edge();
        int ones;
        logic pb;
        if (!RST) begin
            pos = -1;
        end else if (pos < 0) begin
            if (Data_Valid) begin
                frame_bits.delete();
                frame_bits.push_back(1'b0);
                for (int i = 0; i < 8; i++) frame_bits.push_back(P_DATA[i]);
                if (PAR_EN) begin
                    ones = $countones(P_DATA);
                    // parity bit chosen so total ones is even (PAR_TYP=0) or odd (PAR_TYP=1)
                    if ((ones % 2) == 1) pb = PAR_TYP ? 1'b0 : 1'b1;
                    else                 pb = PAR_TYP ? 1'b1 : 1'b0;
                    frame_bits.push_back(pb);
                end
                frame_bits.push_back(1'b1);
`ifdef UART_TX_PRESCALE_EN
                hold = (PRESCALE == 6'd0) ? 1 : int'(PRESCALE);
`else
                hold = 1;
`endif
                pos = 0;
            end
        end else begin
            pos++;
            if (pos >= frame_bits.size() * hold) pos = -1;
        end
        if (pos < 0) begin
            exp_tx = 1'b1; exp_busy = 1'b0;
        end else begin
            exp_tx = frame_bits[pos / hold]; exp_busy = 1'b1;
        end
    endfunction

    task automatic step(input logic dv, input logic [7:0] d, input logic pe, input logic pt);
        Data_Valid = dv; P_DATA = d; PAR_EN = pe; PAR_TYP = pt;
`ifdef UART_TX_PRESCALE_EN
        PRESCALE = cur_ps;
`endif
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        chk_eq("tx", {31'd0, TX_OUT}, {31'd0, exp_tx});
        chk_eq("busy", {31'd0, Busy}, {31'd0, exp_busy});
    endtask

    // Sends one frame, samples one level per bit, counts Busy cycles; optional mid-frame Data_Valid glitch.
    task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input int exp_bits, input logic [31:0] exp_seq, input int glitch_at);
        logic [31:0] seq;
        int c;
        seq = 32'd0;
        c = 0;
        step(1'b1, d, pe, pt);
        while (Busy && c < 200) begin
            if ((c % hold) == 0) seq[c / hold] = TX_OUT;
            c++;
            if (c == glitch_at) step(1'b1, 8'h3C, 1'b0, 1'b1);
            else                step(1'b0, 8'h00, 1'b0, 1'b0);
        end
        chk_eq("busy_len", c, exp_bits * hold);
        chk_eq("bit_seq", seq, exp_seq);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        logic b2b[$];
        int gap;
        RST = 1'b0; P_DATA = 8'h00; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
`ifdef UART_TX_PRESCALE_EN
        PRESCALE = cur_ps;
        hold = 4;
`endif
        repeat (2) @(negedge CLK);
        chk_eq("rst_tx", {31'd0, TX_OUT}, 32'd1);
        chk_eq("rst_busy", {31'd0, Busy}, 32'd0);
        RST = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // 0xA5 even parity: 0,1,0,1,0,0,1,0,1,0,1
        run_frame(8'hA5, 1'b1, 1'b0, 11, 32'h54A, -1);
        // 0x01 odd parity: parity bit 0
        run_frame(8'h01, 1'b1, 1'b1, 11, 32'h402, -1);
        // 0xFF without parity: 0, eight ones, 1
        run_frame(8'hFF, 1'b0, 1'b0, 10, 32'h3FE, -1);
        // Data_Valid pulse during the frame must be ignored
        run_frame(8'hA5, 1'b1, 1'b0, 11, 32'h54A, 3);

        // Data_Valid held high: frames separated by exactly one idle cycle
        for (int i = 0; i < 30 * hold; i++) begin
            step(1'b1, 8'h55, 1'b0, 1'b0);
            b2b.push_back(Busy);
        end
        gap = 10 * hold;
        chk_eq("b2b_last_busy", {31'd0, b2b[gap - 1]}, 32'd1);
        chk_eq("b2b_gap_idle", {31'd0, b2b[gap]}, 32'd0);
        chk_eq("b2b_restart", {31'd0, b2b[gap + 1]}, 32'd1);
        for (int i = 0; i < 12 * hold; i++) step(1'b0, 8'h00, 1'b0, 1'b0);

        // Reset during data bit 4 aborts the frame immediately
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        for (int i = 0; i < 4 * hold + 1; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        RST = 1'b0;
        #1;
        pos = -1;
        chk_eq("midrst_tx", {31'd0, TX_OUT}, 32'd1);
        chk_eq("midrst_busy", {31'd0, Busy}, 32'd0);
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        RST = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0, 8'hA5, 1'b1, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
`ifdef UART_TX_PRESCALE_EN
            cur_ps = 6'($urandom_range(0, 3));
`endif
            step(($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
